cp0_exc_ctrl: RTL and testbench

Exception/interrupt sequencer for the static-pipeline CPU's coprocessor-0 register block. Sits beside CP0 in the ID/EX stages. It arbitrates exceptions, a synchronised external interrupt, `eret`, `mfc0` and `mtc0`, then drives the CP0 control strobes, the `cause` word, the next-PC select and the pipeline flush/stall.

---
 rtl/cp0_exc_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer: arbitrates exceptions, a synchronised interrupt,
// eret, mfc0 and mtc0, and drives CP0 strobes, cause, next-PC select and flush/stall.
module cp0_exc_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        intr,
  input  logic        syscall_id,
  input  logic        unimpl_id,
  input  logic        eret_id,
  input  logic        mfc0_id,
  input  logic        mtc0_id,
  input  logic        bd_id,
  input  logic        ovf_ex,
  input  logic [4:0]  rd_id,
  input  logic        pipe_stall,
  input  logic [31:0] sta,
  output logic        wsta,
  output logic        wcau,
  output logic        wepc,
  output logic        mtc0,
  output logic        exc,
  output logic        inta,
  output logic [1:0]  mfc0,
  output logic [1:0]  selpc,
  output logic [31:0] cause,
  output logic        epc_ex,
  output logic        flush,
  output logic        stall,
  output logic        intack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TAKE = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [4:0] EC_INT = 5'd0;
  localparam logic [4:0] EC_SYS = 5'd8;
  localparam logic [4:0] EC_RI  = 5'd10;
  localparam logic [4:0] EC_OV  = 5'd12;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   pending_q, pending_d;
  logic [1:0]             state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [4:0]             code_q, code_d;
  logic                   src_int_q, src_int_d;
  logic                   src_ovf_q, src_ovf_d;

  logic sync_out, rise;
  logic idle, ovf_ev, sys_ev, uni_ev, int_ev, sync_exc, exc_ev, int_win, accept;
  logic eret_win, cp0_win;
  logic unused_sta;

  assign unused_sta = ^sta[31:4];

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~sync_prev_q;

  assign idle     = (state_q == S_IDLE);
  assign ovf_ev   = ovf_ex & sta[3];
  assign sys_ev   = syscall_id & sta[1];
  assign uni_ev   = unimpl_id & sta[2];
  assign int_ev   = pending_q & sta[0] & ~bd_id & ~pipe_stall;
  assign sync_exc = ovf_ev | sys_ev | uni_ev;
  assign exc_ev   = sync_exc | int_ev;
  assign int_win  = int_ev & ~sync_exc;
  assign accept   = idle & int_win;

  // ID-driven IDLE outputs are combinational, so they are also gated by reset
  assign eret_win = rst & idle & ~exc_ev & eret_id;
  assign cp0_win  = rst & idle & ~exc_ev & ~eret_id;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    src_int_d = src_int_q;
    src_ovf_d = src_ovf_q;
    case (state_q)
      S_IDLE: begin
        if (exc_ev) begin
          state_d   = S_TAKE;
          src_int_d = int_win;
          src_ovf_d = ovf_ev;
          if (ovf_ev)      code_d = EC_OV;
          else if (sys_ev) code_d = EC_SYS;
          else if (uni_ev) code_d = EC_RI;
          else             code_d = EC_INT;
        end
      end
      S_TAKE: begin
        state_d = S_HOLD;
        cnt_d   = 3'd0;
      end
      S_HOLD: begin
        if (cnt_q == 3'(HOLD_CYCLES - 1)) state_d = S_IDLE;
        else                               cnt_d   = cnt_q + 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // an edge arriving in the acceptance cycle re-arms pending
  assign pending_d = (pending_q & ~accept) | rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
      pending_q   <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      code_q      <= 5'd0;
      src_int_q   <= 1'b0;
      src_ovf_q   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], intr};
      sync_prev_q <= sync_out;
      pending_q   <= pending_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      src_int_q   <= src_int_d;
      src_ovf_q   <= src_ovf_d;
    end
  end

  always_comb begin
    wsta   = 1'b0;
    wcau   = 1'b0;
    wepc   = 1'b0;
    mtc0   = 1'b0;
    exc    = 1'b0;
    inta   = 1'b0;
    mfc0   = 2'b00;
    selpc  = 2'b00;
    cause  = 32'd0;
    epc_ex = 1'b0;
    flush  = 1'b0;
    stall  = 1'b0;
    intack = 1'b0;
    if (state_q == S_TAKE) begin
      wsta   = 1'b1;
      wcau   = 1'b1;
      wepc   = 1'b1;
      exc    = 1'b1;
      selpc  = 2'b10;
      flush  = 1'b1;
      inta   = src_int_q;
      intack = src_int_q;
      epc_ex = src_ovf_q;
      cause  = {25'd0, code_q, 2'b00};
    end else if (state_q == S_HOLD) begin
      stall = 1'b1;
    end else if (eret_win) begin
      wsta  = 1'b1;
      selpc = 2'b01;
      flush = 1'b1;
    end else if (cp0_win) begin
      // mtc0 marks the instruction; only recognised registers get a strobe
      if (mtc0_id) begin
        mtc0 = 1'b1;
        wsta = (rd_id == 5'd12);
        wcau = (rd_id == 5'd13);
        wepc = (rd_id == 5'd14);
      end
      if (mfc0_id) begin
        case (rd_id)
          5'd12:   mfc0 = 2'b01;
          5'd13:   mfc0 = 2'b10;
          5'd14:   mfc0 = 2'b11;
          default: mfc0 = 2'b00;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed and randomized checks of cp0_exc_ctrl against a cycle-level behavioural model.
module tb_cp0_exc_ctrl;

  localparam int SYNC = 2;
  localparam int HOLD = 1;

  logic        clk = 1'b0;
  logic        rst, intr, syscall_id, unimpl_id, eret_id, mfc0_id, mtc0_id, bd_id, ovf_ex, pipe_stall;
  logic [4:0]  rd_id;
  logic [31:0] sta;
  logic        wsta, wcau, wepc, mtc0, exc, inta, epc_ex, flush, stall, intack;
  logic [1:0]  mfc0, selpc;
  logic [31:0] cause;

  cp0_exc_ctrl #(.SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .intr(intr), .syscall_id(syscall_id), .unimpl_id(unimpl_id),
    .eret_id(eret_id), .mfc0_id(mfc0_id), .mtc0_id(mtc0_id), .bd_id(bd_id), .ovf_ex(ovf_ex),
    .rd_id(rd_id), .pipe_stall(pipe_stall), .sta(sta), .wsta(wsta), .wcau(wcau), .wepc(wepc),
    .mtc0(mtc0), .exc(exc), .inta(inta), .mfc0(mfc0), .selpc(selpc), .cause(cause),
    .epc_ex(epc_ex), .flush(flush), .stall(stall), .intack(intack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model: an exception in flight, remaining stall cycles, pending interrupt
  bit m_take, m_int, m_ovf, m_pend, m_prev;
  int m_hold_left, m_code;
  bit q_sync[$];

  bit        e_wsta, e_wcau, e_wepc, e_mtc0, e_exc, e_inta, e_epc_ex, e_flush, e_stall, e_intack;
  bit [1:0]  e_mfc0, e_selpc;
  bit [31:0] e_cause;
  bit        seen_intack;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_take = 0; m_int = 0; m_ovf = 0; m_pend = 0; m_prev = 0;
    m_hold_left = 0; m_code = 0;
    q_sync = {};
    repeat (SYNC) q_sync.push_back(1'b0);
  endtask

  task automatic model_outputs();
    bit hi;
    {e_wsta, e_wcau, e_wepc, e_mtc0, e_exc, e_inta, e_epc_ex, e_flush, e_stall, e_intack} = '0;
    e_mfc0 = 0; e_selpc = 0; e_cause = 0;
    if (rst !== 1'b1) return;
    if (m_take) begin
      {e_wsta, e_wcau, e_wepc, e_exc, e_flush} = 5'b11111;
      e_selpc = 2; e_inta = m_int; e_intack = m_int; e_epc_ex = m_ovf;
      e_cause = 32'(m_code) * 4;
    end else if (m_hold_left > 0) begin
      e_stall = 1;
    end else begin
      hi = (ovf_ex & sta[3]) | (syscall_id & sta[1]) | (unimpl_id & sta[2]) |
           (m_pend & sta[0] & ~bd_id & ~pipe_stall);
      if (!hi && eret_id) begin
        e_wsta = 1; e_selpc = 1; e_flush = 1;
      end else if (!hi) begin
        if (mtc0_id) begin
          e_mtc0 = 1;
          e_wsta = (rd_id == 12); e_wcau = (rd_id == 13); e_wepc = (rd_id == 14);
        end
        if (mfc0_id && rd_id >= 12 && rd_id <= 14) e_mfc0 = 2'(rd_id - 11);
      end
    end
  endtask

  task automatic model_edge();
    bit rise, ov, sy, un, it;
    if (rst !== 1'b1) begin model_reset(); return; end
    rise = q_sync[0] & ~m_prev;
    m_prev = q_sync[0];
    q_sync.push_back(intr);
    void'(q_sync.pop_front());
    if (m_take) begin
      m_take = 0; m_hold_left = HOLD;
    end else if (m_hold_left > 0) begin
      m_hold_left--;
    end else begin
      ov = ovf_ex & sta[3]; sy = syscall_id & sta[1]; un = unimpl_id & sta[2];
      it = m_pend & sta[0] & ~bd_id & ~pipe_stall;
      if (ov | sy | un | it) begin
        m_take = 1;
        m_code = ov ? 12 : sy ? 8 : un ? 10 : 0;
        m_int = !(ov | sy | un);
        m_ovf = ov;
        if (m_int) m_pend = 0;
      end
    end
    if (rise) m_pend = 1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wsta"}, 32'(wsta), 32'(e_wsta));
    chk({tag, ".wcau"}, 32'(wcau), 32'(e_wcau));
    chk({tag, ".wepc"}, 32'(wepc), 32'(e_wepc));
    chk({tag, ".mtc0"}, 32'(mtc0), 32'(e_mtc0));
    chk({tag, ".exc"}, 32'(exc), 32'(e_exc));
    chk({tag, ".inta"}, 32'(inta), 32'(e_inta));
    chk({tag, ".mfc0"}, 32'(mfc0), 32'(e_mfc0));
    chk({tag, ".selpc"}, 32'(selpc), 32'(e_selpc));
    chk({tag, ".cause"}, cause, e_cause);
    chk({tag, ".epc_ex"}, 32'(epc_ex), 32'(e_epc_ex));
    chk({tag, ".flush"}, 32'(flush), 32'(e_flush));
    chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
    chk({tag, ".intack"}, 32'(intack), 32'(e_intack));
  endtask

  // called just after a falling edge with inputs already driven
  task automatic step(input string tag);
    #2;
    model_outputs();
    check_all(tag);
    seen_intack = intack;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clr_in();
    {syscall_id, unimpl_id, eret_id, mfc0_id, mtc0_id, bd_id, ovf_ex, pipe_stall} = '0;
    rd_id = 5'd0;
  endtask

  initial begin
    int first_i;
    rst = 1'b0; intr = 1'b1; sta = 32'h1;
    clr_in();
    model_reset();
    @(negedge clk);
    repeat (3) step("reset");

    // release: intack expected in the fifth checked cycle (index 4)
    rst = 1'b1;
    first_i = -1;
    for (int i = 0; i < 10; i++) begin
      step("rst_rel");
      if (seen_intack && first_i < 0) first_i = i;
    end
    chk("intack_cycle", 32'(first_i), 32'd4);

    // syscall enabled
    sta = 32'h2; syscall_id = 1'b1;
    step("sys_evt");
    clr_in();
    #1 chk("sys_cause", cause, 32'h20);
    chk("sys_exc", 32'(exc), 32'd1);
    step("sys_take");
    #1 chk("sys_stall", 32'(stall), 32'd1);
    step("sys_hold");

    // syscall masked
    sta = 32'h0; syscall_id = 1'b1;
    step("sys_mask");
    clr_in();
    #1 chk("sys_mask_exc", 32'(exc), 32'd0);
    step("sys_mask2");

    // build pending, then same-cycle overflow + syscall + pending
    intr = 1'b0;
    repeat (3) step("int_low");
    intr = 1'b1;
    repeat (3) step("int_sync");
    sta = 32'hF; ovf_ex = 1'b1; syscall_id = 1'b1;
    step("prio_evt");
    clr_in();
    #1 chk("prio_cause", cause, 32'h30);
    chk("prio_epc_ex", 32'(epc_ex), 32'd1);
    step("prio_take");
    sta = 32'h1;
    step("prio_hold");
    step("prio_int_evt");
    #1 chk("prio_int_ack", 32'(intack), 32'd1);
    step("prio_int_take");
    step("prio_int_hold");

    // interrupt deferred while in a delay slot
    sta = 32'h0; intr = 1'b0;
    repeat (3) step("def_low");
    intr = 1'b1;
    repeat (3) step("def_sync");
    sta = 32'h1; bd_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("def_noexc", 32'(exc), 32'd0);
      step("def_bd");
    end
    bd_id = 1'b0;
    #1 chk("def_noexc_last", 32'(exc), 32'd0);
    step("def_go");
    #1 chk("def_ack", 32'(intack), 32'd1);
    step("def_take");
    step("def_hold");

    // mtc0 / mfc0 decoding
    sta = 32'h0; mtc0_id = 1'b1; rd_id = 5'd13;
    #1 chk("mtc0_wcau", 32'(wcau), 32'd1);
    chk("mtc0_wsta", 32'(wsta), 32'd0);
    step("mtc0_13");
    clr_in(); mfc0_id = 1'b1; rd_id = 5'd14;
    #1 chk("mfc0_14", 32'(mfc0), 32'd3);
    step("mfc0_14");
    clr_in(); mfc0_id = 1'b1; mtc0_id = 1'b1; rd_id = 5'd5;
    #1 chk("rd5_mfc0", 32'(mfc0), 32'd0);
    step("rd5");
    mtc0_id = 1'b0; mfc0_id = 1'b0; ovf_ex = 1'b1; sta = 32'h8; mtc0_id = 1'b1; rd_id = 5'd12;
    #1 chk("ovf_sup_mtc0", 32'(wsta), 32'd0);
    step("ovf_mtc0");
    clr_in();
    step("ovf_take");
    step("ovf_hold");

    // eret in IDLE, then eret ignored during HOLD
    eret_id = 1'b1;
    #1 chk("eret_selpc", 32'(selpc), 32'd1);
    step("eret_idle");
    clr_in(); sta = 32'h2; syscall_id = 1'b1;
    step("eret_sys");
    clr_in();
    step("eret_take");
    eret_id = 1'b1;
    #1 chk("eret_hold_sel", 32'(selpc), 32'd0);
    step("eret_hold");
    clr_in();

    // asynchronous reset in the middle of TAKE
    syscall_id = 1'b1;
    step("ar_evt");
    clr_in();
    #1 rst = 1'b0;
    #1;
    model_reset();
    model_outputs();
    check_all("async_rst");
    @(posedge clk); model_edge(); @(negedge clk);
    rst = 1'b1;
    step("ar_rel");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      syscall_id = ($urandom_range(0, 9) == 0);
      unimpl_id  = ($urandom_range(0, 9) == 0);
      ovf_ex     = ($urandom_range(0, 11) == 0);
      eret_id    = ($urandom_range(0, 7) == 0);
      mtc0_id    = ($urandom_range(0, 3) == 0);
      mfc0_id    = ($urandom_range(0, 3) == 0);
      bd_id      = ($urandom_range(0, 3) == 0);
      pipe_stall = ($urandom_range(0, 4) == 0);
      rd_id      = ($urandom_range(0, 1) == 0) ? 5'(11 + $urandom_range(0, 4)) : 5'($urandom);
      sta        = {$urandom} & 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) intr = ~intr;
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
